// File: rtl/crop_pkg.sv
// rtl/crop_pkg.sv - shared types for the crop / crop-paste stages
package crop_pkg;

  localparam int ROW_BITS = 10;
  localparam int COL_BITS = 10;

  typedef enum logic {IDLE, STREAM} paste_state_t;

  typedef logic [ROW_BITS-1:0] row_idx_t;
  typedef logic [COL_BITS-1:0] col_idx_t;

endpackage

// File: rtl/crop_raster_counter.sv
// rtl/crop_raster_counter.sv - row-major raster position counter
module raster_counter #(
  parameter int ROWS  = 100,
  parameter int COLS  = 160,
  parameter int ROW_W = 10,
  parameter int COL_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);

  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  assign last = (row == ROW_LAST) && (col == COL_LAST);

  // step through the frame one pixel per enable, wrapping col into row
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/crop_paste.sv
// rtl/crop_paste.sv - pastes a cropped pixel stream back into a filled full frame
module crop_paste
  import crop_pkg::*;
#(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = ROW_BITS,
  parameter int IMG_COL_BITWIDTH = COL_BITS,
  parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
  input  logic                        pixel_out_TREADY
);

  // largest origin that still keeps the whole window inside the frame
  localparam row_idx_t Y_MAX = row_idx_t'(IN_ROWS - OUT_ROWS);
  localparam col_idx_t X_MAX = col_idx_t'(IN_COLS - OUT_COLS);

  paste_state_t state, next_state;

  logic     y_cap, x_cap;
  row_idx_t y1;
  col_idx_t x1;
  row_idx_t row;
  col_idx_t col;
  logic     last;

  logic                y_hs, x_hs;
  logic                in_win, adv, step, frame_done;
  logic [ROW_BITS:0]   y_end;
  logic [COL_BITS:0]   x_end;

  assign crop_Y1_TREADY = (state == IDLE) & ~y_cap & ~reset;
  assign crop_X1_TREADY = (state == IDLE) & ~x_cap & ~reset;
  assign y_hs = crop_Y1_TVALID & crop_Y1_TREADY;
  assign x_hs = crop_X1_TVALID & crop_X1_TREADY;

  assign y_end  = {1'b0, y1} + (ROW_BITS + 1)'(OUT_ROWS);
  assign x_end  = {1'b0, x1} + (COL_BITS + 1)'(OUT_COLS);
  assign in_win = (row >= y1) && ({1'b0, row} < y_end) &&
                  (col >= x1) && ({1'b0, col} < x_end);

  // the output register can take a new pixel when empty or being drained
  assign adv = ~pixel_out_TVALID | pixel_out_TREADY;

  assign pixel_in_TREADY = (state == STREAM) & in_win & adv & ~reset;

  // a raster position is emitted when fill is free or a crop pixel arrives
  assign step       = (state == STREAM) & adv & (~in_win | pixel_in_TVALID);
  assign frame_done = step & last;

  raster_counter #(
    .ROWS  (IN_ROWS),
    .COLS  (IN_COLS),
    .ROW_W (ROW_BITS),
    .COL_W (COL_BITS)
  ) u_raster (
    .clk   (clk),
    .reset (reset),
    .en    (step),
    .clr   (frame_done),
    .row   (row),
    .col   (col),
    .last  (last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // start streaming once both origin coordinates are held; stop after the last pixel
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (y_cap && x_cap) next_state = STREAM;
      STREAM:  if (frame_done)     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // capture each coordinate independently, clamped so the window fits the frame
  always_ff @(posedge clk) begin
    if (reset) begin
      y_cap <= 1'b0;
      x_cap <= 1'b0;
      y1    <= '0;
      x1    <= '0;
    end else if (frame_done) begin
      y_cap <= 1'b0;
      x_cap <= 1'b0;
    end else begin
      if (y_hs) begin
        y_cap <= 1'b1;
        y1    <= (row_idx_t'(crop_Y1_TDATA) > Y_MAX) ? Y_MAX : row_idx_t'(crop_Y1_TDATA);
      end
      if (x_hs) begin
        x_cap <= 1'b1;
        x1    <= (col_idx_t'(crop_X1_TDATA) > X_MAX) ? X_MAX : col_idx_t'(crop_X1_TDATA);
      end
    end
  end

  // output register: load fill or crop pixel, otherwise bubble/drain when consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      pixel_out_TVALID <= 1'b0;
      pixel_out_TDATA  <= '0;
    end else if (step) begin
      pixel_out_TVALID <= 1'b1;
      pixel_out_TDATA  <= in_win ? pixel_in_TDATA : FILL_VALUE;
    end else if (adv) begin
      pixel_out_TVALID <= 1'b0;
    end
  end

endmodule
